cfg_recfg_sched: RTL and testbench
==================================

// Module: cfg_recfg_sched
// PURPOSE
//  Schedules the secondary-bootaddr reconfiguration trigger for the CC_CFG_CTRL
//  primitive. It holds off after power-up and requires an unlock key before
//  acting. It grants one of NUM_REQ requesters, or a watchdog timeout, and then
//  drives the RECFG level. Sits at top level between user logic and CC_CFG_CTRL.
//  CC_CFG_CTRL CLK/EN/DATA/VALID stay tied to 0 outside this block.
// PARAMETERS
//  NUM_REQ        2        number of reconfiguration requesters (1..8)
//  STARTUP_CYCLES 1000000  cycles after reset before any request is honoured
//  ARM_KEY        8'hA5    key that must be presented to arm the scheduler
//  ARM_WINDOW     4096     cycles an arm stays valid without a request
//  GUARD_CYCLES   256      drain delay between grant and RECFG assertion
//  WDT_CYCLES     0        watchdog period in cycles; 0 disables the watchdog
// PORTS
//  clk        in   1        system clock (PLL CLK0)
//  rstn       in   1        asynchronous active-low reset
//  req        in   NUM_REQ  level requests; bit i = requester i
//  arm_valid  in   1        one-cycle strobe qualifying arm_key
//  arm_key    in   8        unlock key
//  wdt_kick   in   1        watchdog restart strobe
//  recfg      out  1        to CC_CFG_CTRL.RECFG; high = reconfigure
//  armed      out  1        scheduler is in ARMED
//  busy       out  1        in GUARD or FIRE
//  grant      out  NUM_REQ  one-hot grant, held from GUARD until reset
//  cause      out  4        0..NUM_REQ-1 = requester, NUM_REQ = watchdog
//  ready      out  1        startup hold-off has finished
// BEHAVIOUR
//  - Reset (async assert, sync release): state=INIT, all counters 0.
//    Outputs recfg, armed, busy, grant, cause and ready are all 0.
//  - INIT: the counter increments every cycle. At count==STARTUP_CYCLES-1 the
//    next state is IDLE and ready=1; ready stays 1 until reset.
//  - IDLE: arm_valid && arm_key==ARM_KEY -> ARMED, arm timer cleared.
//    A wrong key is ignored. A request without an arm is ignored.
//  - ARMED: if any req bit is set, the lowest index i wins (fixed priority).
//    grant[i] and cause=i register on that edge, and the next state is GUARD.
//    The arm timer reaches ARM_WINDOW-1 with no request -> IDLE.
//    A re-arm (key match) in ARMED restarts the arm timer.
//    If a request and the timeout occur in the same cycle, the request wins.
//  - GUARD: busy=1. Count GUARD_CYCLES, then go to FIRE. req, arm and kick
//    inputs are ignored.
//  - FIRE: recfg=1 and busy=1. Terminal; only rstn leaves this state.
//  - Watchdog (WDT_CYCLES>0): the timer runs in IDLE and ARMED.
//    wdt_kick clears it, and it is cleared on entry to IDLE from INIT.
//    The timer reaching WDT_CYCLES-1 forces GUARD with cause=NUM_REQ and
//    grant=0, bypassing the arm. If the expiry coincides with a req grant,
//    the req wins. If a kick arrives in the expiry cycle, the kick wins.
//    The watchdog is frozen in INIT, GUARD and FIRE.
//  - recfg is a registered output, glitch-free and monotonic
//    (0 until FIRE, 1 after).
//  - rstn asserted mid-GUARD or mid-FIRE aborts the sequence. recfg drops
//    asynchronously and the block returns to INIT.
//  - Counter width is clog2 of max(STARTUP, WINDOW, GUARD, WDT). Counters
//    saturate and never wrap.
//  - armed = (state==ARMED). Latency from arm strobe to armed is 1 cycle.
//    Latency from req to grant is 1 cycle.
//    Latency from req to recfg is GUARD_CYCLES+1 cycles.
// STRUCTURE
//  - Shared package cfg_sched_pkg: state enum {INIT, IDLE, ARMED, GUARD, FIRE},
//    CAUSE_WDT localparam function, clog2 helper.
//  - Sub-module prio_enc (NUM_REQ -> one-hot + index, lowest wins).
//    It is instantiated once.
//  - Single FSM with one shared down-phase counter plus a separate watchdog
//    counter.
// TESTING
//  Use STARTUP=8, ARM_WINDOW=16, GUARD=4, WDT=0 unless a scenario says otherwise.
//  1 Reset release, req=2'b11 held, no arm -> ready rises at cycle 8; recfg
//    stays 0 for 100 cycles.
//  2 Arm with key A5, req=2'b10 on the next cycle -> grant=2'b10, cause=1,
//    busy=1; recfg=1 exactly 5 cycles after req.
//  3 Arm with key A5 and no req -> armed=1 for 16 cycles, then IDLE;
//    a later req gives no grant.
//    Arm with key 5A -> armed stays 0.
//  4 Arm, then req=2'b11 in one cycle -> grant=2'b01, cause=0.
//    Changing req during GUARD has no effect.
//  5 WDT=32: kick every 20 cycles for 200 cycles -> no fire. Stop kicking ->
//    cause=2, grant=0, recfg=1 at 32+4+1 cycles after the last kick.
//  6 rstn low 2 cycles after recfg=1 -> recfg=0 immediately. After release the
//    block is in INIT and the ready-at-8 behaviour repeats.

Source files
------------

// File: rtl/cfg_sched_pkg.sv
// rtl/cfg_sched_pkg.sv - shared types and helpers for the reconfiguration scheduler
package cfg_sched_pkg;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_ARMED,
    ST_GUARD,
    ST_FIRE
  } state_t;

  // Bits needed to hold 0..n-1, never narrower than one bit.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    for (int i = 1; i < 32; i++)
      if ((longint'(1) << i) < longint'(n)) w = i + 1;
    return w;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int cause_wdt(input int num_req);
    return num_req;
  endfunction

endpackage

// File: rtl/cfg_recfg_sched_prio_enc.sv
// rtl/cfg_recfg_sched_prio_enc.sv - fixed-priority encoder, lowest index wins
module prio_enc #(
  parameter int N = 2
) (
  input  logic [N-1:0] req,
  output logic [N-1:0] onehot,
  output logic [3:0]   idx,
  output logic         any
);

  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = |req;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        onehot    = '0;
        onehot[i] = 1'b1;
        idx       = 4'(i);
      end
    end
  end

endmodule

// File: rtl/cfg_recfg_sched.sv
// rtl/cfg_recfg_sched.sv - schedules the CC_CFG_CTRL secondary-bootaddr RECFG trigger
module cfg_recfg_sched
  import cfg_sched_pkg::*;
#(
  parameter int         NUM_REQ        = 2,
  parameter int         STARTUP_CYCLES = 1000000,
  parameter logic [7:0] ARM_KEY        = 8'hA5,
  parameter int         ARM_WINDOW     = 4096,
  parameter int         GUARD_CYCLES   = 256,
  parameter int         WDT_CYCLES     = 0
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [NUM_REQ-1:0] req,
  input  logic               arm_valid,
  input  logic [7:0]         arm_key,
  input  logic               wdt_kick,
  output logic               recfg,
  output logic               armed,
  output logic               busy,
  output logic [NUM_REQ-1:0] grant,
  output logic [3:0]         cause,
  output logic               ready
);

  localparam int CW = clog2(max2(max2(STARTUP_CYCLES, ARM_WINDOW), max2(GUARD_CYCLES, WDT_CYCLES)));
  localparam logic [CW-1:0] STARTUP_LAST = CW'(STARTUP_CYCLES - 1);
  localparam logic [CW-1:0] ARM_LAST     = CW'(ARM_WINDOW - 1);
  localparam logic [CW-1:0] GUARD_LAST   = CW'(GUARD_CYCLES - 1);
  localparam logic [CW-1:0] WDT_LAST     = CW'((WDT_CYCLES > 0) ? WDT_CYCLES - 1 : 0);
  localparam logic [CW-1:0] CNT_MAX      = '1;
  localparam logic [3:0]    CAUSE_WDT    = 4'(cause_wdt(NUM_REQ));

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [CW-1:0]      wdt_cnt;
  logic [NUM_REQ-1:0] req_onehot;
  logic [3:0]         req_idx;
  logic               req_any;
  logic               key_ok;
  logic               wdt_live;
  logic               wdt_exp;

  prio_enc #(
    .N(NUM_REQ)
  ) u_prio (
    .req    (req),
    .onehot (req_onehot),
    .idx    (req_idx),
    .any    (req_any)
  );

  assign key_ok   = arm_valid && (arm_key == ARM_KEY);
  assign wdt_live = (WDT_CYCLES > 0) && ((state == ST_IDLE) || (state == ST_ARMED));
  // A kick in the expiry cycle rescues the timer.
  assign wdt_exp  = wdt_live && (wdt_cnt == WDT_LAST) && !wdt_kick;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= ST_INIT;
      cnt     <= '0;
      wdt_cnt <= '0;
      recfg   <= 1'b0;
      armed   <= 1'b0;
      busy    <= 1'b0;
      grant   <= '0;
      cause   <= '0;
      ready   <= 1'b0;
    end else begin
      if (wdt_live) begin
        if (wdt_kick)
          wdt_cnt <= '0;
        else if (wdt_cnt != CNT_MAX)
          wdt_cnt <= wdt_cnt + 1'b1;
      end

      case (state)
        ST_INIT: begin
          if (cnt == STARTUP_LAST) begin
            state   <= ST_IDLE;
            ready   <= 1'b1;
            cnt     <= '0;
            wdt_cnt <= '0;
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_IDLE: begin
          if (wdt_exp) begin
            state <= ST_GUARD;
            busy  <= 1'b1;
            grant <= '0;
            cause <= CAUSE_WDT;
            cnt   <= '0;
          end else if (key_ok) begin
            state <= ST_ARMED;
            armed <= 1'b1;
            cnt   <= '0;
          end
        end

        // Priority: request, then watchdog, then re-arm, then arm timeout.
        ST_ARMED: begin
          if (req_any) begin
            state <= ST_GUARD;
            armed <= 1'b0;
            busy  <= 1'b1;
            grant <= req_onehot;
            cause <= req_idx;
            cnt   <= '0;
          end else if (wdt_exp) begin
            state <= ST_GUARD;
            armed <= 1'b0;
            busy  <= 1'b1;
            grant <= '0;
            cause <= CAUSE_WDT;
            cnt   <= '0;
          end else if (key_ok) begin
            cnt <= '0;
          end else if (cnt == ARM_LAST) begin
            state <= ST_IDLE;
            armed <= 1'b0;
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_GUARD: begin
          if (cnt == GUARD_LAST) begin
            state <= ST_FIRE;
            recfg <= 1'b1;
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_FIRE: begin
          recfg <= 1'b1;
        end

        default: begin
          state <= ST_INIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cfg_recfg_sched.sv
// tb/tb_cfg_recfg_sched.sv - scoreboard bench for cfg_recfg_sched
module tb_cfg_recfg_sched;

  localparam int MAXN = 256;

  typedef struct {
    int         cyc;
    logic [9:0] vec;
  } ev_t;

  logic       clk = 1'b0;
  logic       rstn0, rstn1;
  logic [1:0] req;
  logic       arm_valid;
  logic [7:0] arm_key;
  logic       wdt_kick;
  logic       recfg0, armed0, busy0, ready0;
  logic       recfg1, armed1, busy1, ready1;
  logic [1:0] grant0, grant1;
  logic [3:0] cause0, cause1;

  logic [1:0] p_req  [MAXN];
  logic       p_arm  [MAXN];
  logic [7:0] p_key  [MAXN];
  logic       p_kick [MAXN];

  ev_t        exp_q[$];
  ev_t        ev;
  logic [9:0] prev = '0;
  logic [9:0] cur;
  logic [9:0] mfinal;
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         act = 0;

  always #5 clk = ~clk;

  cfg_recfg_sched #(
    .NUM_REQ(2), .STARTUP_CYCLES(8), .ARM_KEY(8'hA5),
    .ARM_WINDOW(16), .GUARD_CYCLES(4), .WDT_CYCLES(0)
  ) dut0 (
    .clk(clk), .rstn(rstn0), .req(req), .arm_valid(arm_valid), .arm_key(arm_key),
    .wdt_kick(wdt_kick), .recfg(recfg0), .armed(armed0), .busy(busy0),
    .grant(grant0), .cause(cause0), .ready(ready0)
  );

  cfg_recfg_sched #(
    .NUM_REQ(2), .STARTUP_CYCLES(8), .ARM_KEY(8'hA5),
    .ARM_WINDOW(16), .GUARD_CYCLES(4), .WDT_CYCLES(32)
  ) dut1 (
    .clk(clk), .rstn(rstn1), .req(req), .arm_valid(arm_valid), .arm_key(arm_key),
    .wdt_kick(wdt_kick), .recfg(recfg1), .armed(armed1), .busy(busy1),
    .grant(grant1), .cause(cause1), .ready(ready1)
  );

  function automatic logic [9:0] mkvec(input logic rf, input logic ar, input logic bz,
                                       input logic [1:0] gr, input logic [3:0] ca, input logic rd);
    return {rf, ar, bz, gr, ca, rd};
  endfunction

  function automatic logic [9:0] dut_vec(input int a);
    if (a == 0) return {recfg0, armed0, busy0, grant0, cause0, ready0};
    return {recfg1, armed1, busy1, grant1, cause1, ready1};
  endfunction

  function automatic logic active_rstn();
    return (act == 0) ? rstn0 : rstn1;
  endfunction

  // Monitor: every change of the output vector must match the next expected event.
  always @(negedge clk) begin
    if (active_rstn()) begin
      cur = dut_vec(act);
      if (cur !== prev) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_change cyc=%0d got=%b want=no_change", cyc, cur);
        end else begin
          ev = exp_q.pop_front();
          if (ev.cyc != cyc || ev.vec !== cur) begin
            bad++;
            $display("FAIL out_change got cyc=%0d vec=%b want cyc=%0d vec=%b", cyc, cur, ev.cyc, ev.vec);
          end
        end
        prev = cur;
      end
    end else begin
      prev = '0;
    end
  end

  task automatic check(input string name, input logic [9:0] got, input logic [9:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%b want=%b", name, cyc, got, want);
    end
  endtask

  task automatic push(input int c, input logic [9:0] v, input int n);
    ev_t e;
    if (c < n) begin
      e.cyc = c;
      e.vec = v;
      exp_q.push_back(e);
      mfinal = v;
    end
  endtask

  // Reference model: scans the stimulus plan cycle by cycle from the end of startup.
  task automatic model_run(input int wdt, input int n);
    logic [9:0] v;
    logic [1:0] gv;
    int         abase, wbase, idx;
    bit         armd, done, key_ok, wexp;
    exp_q.delete();
    mfinal = '0;
    push(8, mkvec(1'b0, 1'b0, 1'b0, 2'b00, 4'd0, 1'b1), n);
    armd = 0; done = 0; wbase = 8; abase = 0;
    for (int c = 8; c < n && !done; c++) begin
      key_ok = p_arm[c] && (p_key[c] == 8'hA5);
      wexp   = (wdt > 0) && (c - wbase == wdt - 1) && !p_kick[c];
      if (p_kick[c]) wbase = c + 1;
      idx = -1;
      if (armd && p_req[c] != 2'b00) idx = p_req[c][0] ? 0 : 1;
      else if (wexp) idx = 2;
      if (idx >= 0) begin
        gv = (idx == 2) ? 2'b00 : ((idx == 0) ? 2'b01 : 2'b10);
        v  = mkvec(1'b0, 1'b0, 1'b1, gv, 4'(idx), 1'b1);
        push(c + 1, v, n);
        v[9] = 1'b1;
        push(c + 5, v, n);
        done = 1;
      end else if (key_ok) begin
        abase = c + 1;
        if (!armd) push(c + 1, mkvec(1'b0, 1'b1, 1'b0, 2'b00, 4'd0, 1'b1), n);
        armd = 1;
      end else if (armd && (c - abase == 15)) begin
        armd = 0;
        push(c + 1, mkvec(1'b0, 1'b0, 1'b0, 2'b00, 4'd0, 1'b1), n);
      end
    end
  endtask

  task automatic clear_plan();
    for (int c = 0; c < MAXN; c++) begin
      p_req[c] = 2'b00; p_arm[c] = 1'b0; p_key[c] = 8'h00; p_kick[c] = 1'b0;
    end
  endtask

  task automatic gen_random(input int a, input int n);
    logic [1:0] r;
    int         hold;
    r = 2'b00; hold = 0;
    clear_plan();
    for (int c = 0; c < n; c++) begin
      if (hold == 0) begin
        r    = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        hold = $urandom_range(1, 12);
      end
      hold--;
      p_req[c]  = r;
      p_arm[c]  = ($urandom_range(0, 9) == 0);
      p_key[c]  = ($urandom_range(0, 1) == 0) ? 8'hA5 : 8'($urandom_range(0, 255));
      p_kick[c] = (a == 1) && ($urandom_range(0, 19) == 0);
    end
  endtask

  task automatic apply(input int c);
    req = p_req[c]; arm_valid = p_arm[c]; arm_key = p_key[c]; wdt_kick = p_kick[c];
  endtask

  task automatic run_plan(input int a, input int n);
    act = a;
    model_run((a == 0) ? 0 : 32, n);
    @(posedge clk); #1;
    cyc = 0;
    apply(0);
    if (a == 0) rstn0 = 1'b1; else rstn1 = 1'b1;
    for (int c = 1; c < n; c++) begin
      @(posedge clk); #1;
      cyc = c;
      apply(c);
    end
    @(negedge clk); #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL missing_event got=none want cyc=%0d vec=%b", exp_q[0].cyc, exp_q[0].vec);
    end
    exp_q.delete();
    check("final_state", dut_vec(a), mfinal);
    rstn0 = 1'b0; rstn1 = 1'b0;
    #1;
    check("reset_drop", dut_vec(a), 10'b0);
    req = 2'b00; arm_valid = 1'b0; arm_key = 8'h00; wdt_kick = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    rstn0 = 1'b0; rstn1 = 1'b0;
    req = 2'b00; arm_valid = 1'b0; arm_key = 8'h00; wdt_kick = 1'b0;
    repeat (3) @(posedge clk);

    clear_plan();
    for (int c = 0; c < 108; c++) p_req[c] = 2'b11;
    run_plan(0, 108);

    clear_plan();
    p_arm[10] = 1'b1; p_key[10] = 8'hA5;
    for (int c = 11; c < 24; c++) p_req[c] = 2'b10;
    run_plan(0, 24);

    clear_plan();
    p_arm[10] = 1'b1; p_key[10] = 8'hA5;
    for (int c = 40; c < 60; c++) p_req[c] = 2'b01;
    p_arm[70] = 1'b1; p_key[70] = 8'h5A;
    for (int c = 75; c < 90; c++) p_req[c] = 2'b11;
    run_plan(0, 90);

    clear_plan();
    p_arm[10] = 1'b1; p_key[10] = 8'hA5;
    p_req[11] = 2'b11;
    for (int c = 12; c < 24; c++) begin
      p_req[c] = 2'($urandom_range(0, 3));
      p_arm[c] = 1'b1; p_key[c] = 8'hA5;
    end
    run_plan(0, 24);

    clear_plan();
    for (int k = 0; k < 10; k++) p_kick[8 + 20 * k] = 1'b1;
    run_plan(1, 240);

    clear_plan();
    p_arm[10] = 1'b1; p_key[10] = 8'hA5;
    for (int c = 11; c < 19; c++) p_req[c] = 2'b10;
    run_plan(0, 19);

    for (int k = 0; k < 16; k++) begin
      int n;
      n = $urandom_range(60, 200);
      gen_random(k % 2, n);
      run_plan(k % 2, n);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
